// File: rtl/cntr_udmod_nb.sv
// Up/down modulo counter with WRAP, SAT and ONESHOT modes, clamped load, a combinational
// ripple carry and a registered terminal-count pulse.
module cntr_udmod_nb #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic [n-1:0] D,
  input  logic [n-1:0] max,
  input  logic [1:0]   mode,
  input  logic         start,
  output logic [n-1:0] count,
  output logic         rco,
  output logic         tc,
  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] ModeSat     = 2'b01;
  localparam logic [1:0] ModeOneshot = 2'b10;

  state_e       state_q, state_d;
  logic [n-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         terminal;
  logic         sat;
  logic [n-1:0] step_val;

  always_comb begin
    terminal = up ? (count_q >= max) : (count_q == '0);
    sat      = (mode == ModeSat);
    step_val = count_q;
    if (up) begin
      if (terminal) step_val = sat ? max : '0;
      else          step_val = count_q + n'(1);
    end else begin
      // A count left above a lowered max re-enters the legal range at max.
      if (count_q == '0)     step_val = sat ? '0 : max;
      else if (count_q > max) step_val = max;
      else                    step_val = count_q - n'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (ld) begin
      count_d = (D > max) ? max : D;
      state_d = StIdle;
    end else if (mode == ModeOneshot) begin
      case (state_q)
        StIdle: begin
          if (start) state_d = StRun;
        end
        StRun: begin
          if (en) begin
            if (terminal) begin
              state_d = StDone;
              tc_d    = 1'b1;
            end else begin
              count_d = step_val;
            end
          end
        end
        StDone: begin
          if (start) begin
            state_d = StRun;
            count_d = up ? '0 : max;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      state_d = StIdle;
      if (en) begin
        count_d = step_val;
        tc_d    = terminal;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      state_q <= StIdle;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun);
  assign rco   = en & terminal;

endmodule

// File: doc/cntr_udmod_nb.md
CNTR_UDMOD_NB -- requirements
Module: cntr_udmod_nb

Interface
REQ-001 Parameter: n, default 8, counter width in bits (n >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  count enable; without en, count holds.
REQ-005 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 ld  input  1  synchronous load of D.
REQ-007 D  input  n  load value.
REQ-008 max  input  n  inclusive upper bound; legal range of count is 0..max.
REQ-009 mode  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 treated as WRAP.
REQ-010 start  input  1  ONESHOT arm/restart request, level-sampled.
REQ-011 count  output  n  registered counter value.
REQ-012 rco  output  1  combinational ripple carry for cascading.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 busy  output  1  registered; high while the ONESHOT FSM is in RUN.

Function
REQ-015 Priority per clock edge SHALL be clr > ld > stepping.
REQ-016 ld SHALL load count <= D when D <= max, else count <= max (clamped); ld SHALL NOT assert tc.
REQ-017 Terminal SHALL mean count >= max when up=1, and count == 0 when up=0.
REQ-018 rco SHALL equal en & terminal, evaluated in every mode including FSM IDLE/DONE.
REQ-019 WRAP, en=1: up at terminal -> 0, else +1; down at 0 -> max, else -1.
REQ-020 SAT, en=1: up at terminal -> max, else +1; down at 0 -> hold 0, else -1.
REQ-021 If count > max (max lowered at runtime), the next enabled down step SHALL produce max; up behaves per terminal rules.
REQ-022 max = 0 SHALL be legal: count stays 0; terminal every enabled cycle in either direction.
REQ-023 tc SHALL be high exactly one cycle after any edge where en=1, terminal=1 and stepping applied (WRAP, SAT, or ONESHOT RUN); otherwise low.
REQ-024 ONESHOT FSM states IDLE, RUN, DONE; FSM SHALL be forced to IDLE on any cycle mode != 10.
REQ-025 IDLE: count holds regardless of en; start=1 -> RUN, count unchanged that edge.
REQ-026 RUN: en=1 and not terminal -> step +/-1; en=1 and terminal -> DONE, count holds, tc pulses.
REQ-027 DONE: count holds; start=1 -> RUN with count <= 0 if up=1, else max.
REQ-028 ld while mode = ONESHOT SHALL load per REQ-016 and force FSM to IDLE.
REQ-029 busy SHALL be 1 iff FSM state is RUN.
REQ-030 Direction change mid-count SHALL take effect on the same edge; no pipeline or flush.
REQ-031 All arithmetic SHALL be n-bit modulo and never produce a value outside 0..max after any step.

Reset
REQ-032 clr=1 SHALL immediately force count=0, tc=0, busy=0, FSM=IDLE, independent of clk.
REQ-033 clr released mid-operation SHALL resume from count 0 in IDLE on the first edge with clr=0.
REQ-034 rco SHALL follow REQ-018 during and after reset, because count=0 with up=0, en=1 gives rco=1.

Verification
REQ-035 n=8, max=9, WRAP, up=1, en=1 from 0 for 12 edges -> count 1..9,0,1,2; rco high at count=9; tc high the cycle after count 9->0.
REQ-036 SAT, max=9, up=0 from count=2 for 4 edges -> 1,0,0,0; tc pulses after each held-at-0 edge.
REQ-037 ONESHOT, max=3, up=1, start pulse then en=1 -> busy=1, count 1,2,3, then DONE with busy=0 and single tc; start again -> count=0, RUN.
REQ-038 count=200, ld=1 with D=250, max=240 -> count=240; then max=100 with up=0, en=1 -> count=100.
REQ-039 Assert clr between clock edges during RUN with count=5 -> count=0, busy=0, tc=0 immediately; ld=en=1 with clr=1 -> no load.
REQ-040 max=0, WRAP, en=1, toggle up each cycle -> count stays 0, rco=1 every cycle, tc=1 continuously.
